gray_run_ctrl: RTL
==================

GRAY_RUN_CTRL -- requirements
Module: gray_run_ctrl

Interface
REQ-001 Parameter: LEN_W, default 4, width of run-length field and remaining-step counter.
REQ-002 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  reset, asynchronous, active-high.
REQ-004 Port: Start  input  1  run request, sampled at rising edge.
REQ-005 Port: Len  input  LEN_W  number of count steps for the run, captured with an accepted Start.
REQ-006 Port: Pause  input  1  level; suspends stepping while high.
REQ-007 Port: Abort  input  1  terminates the current run without Done.
REQ-008 Port: Busy  output  1  high in RUN or HOLD.
REQ-009 Port: Done  output  1  high for exactly one cycle, in DONE state.
REQ-010 Port: Remaining  output  LEN_W  steps still to execute in the current run.
REQ-011 Port: Output  output  3  Gray code of internal binary count: {c[2], c[2]^c[1], c[1]^c[0]}.
REQ-012 Port: Overflow  output  1  sticky flag; set when count wraps 7->0.

Function
REQ-013 FSM states IDLE, RUN, HOLD, DONE; one step = binary count +1 mod 8, all registered.
REQ-014 IDLE: Start=1, Len!=0 -> RUN, Remaining<=Len, Overflow<=0; Start=1, Len=0 -> DONE, no step, Overflow<=0.
REQ-015 Start in RUN, HOLD or DONE is ignored; Len is not re-captured.
REQ-016 RUN, Abort=0, Pause=0: one step per edge, Remaining<=Remaining-1; when Remaining==1, go to DONE on the same edge.
REQ-017 RUN, Pause=1, Abort=0 -> HOLD; no step on that edge.
REQ-018 HOLD: Pause=0 -> RUN with no step on that edge; Pause=1 -> stay in HOLD.
REQ-019 Abort=1 in RUN or HOLD -> IDLE; no step, Remaining<=0, count retained, Done not asserted; Abort overrides Pause.
REQ-020 DONE -> IDLE unconditionally after one cycle; Remaining=0 in DONE.
REQ-021 Count is not cleared between runs; a new run continues from the current value.
REQ-022 A step from count 7 sets Overflow=1; it stays set until the next accepted Start or Reset, including across multiple wraps.
REQ-023 Output is combinational from the count register only: glitch-free Gray, changes one bit per step.
REQ-024 Abort and Pause are ignored in IDLE and DONE.

Reset
REQ-025 Reset=1 forces the following immediately, independent of Clk: state IDLE, count=0 (Output=000), Remaining=0, Overflow=0, Busy=0, Done=0.
REQ-026 Reset asserted mid-run discards the run; no Done is produced for it after release.
REQ-027 First Start honoured at the first rising edge after Reset deasserts.

Structure
REQ-028 Shared package holds the FSM state encoding (2-bit constants IDLE/RUN/HOLD/DONE) and the 3-bit count width constant.
REQ-029 The Gray counter is a sub-module gray_core (inputs Clk, Reset, Step; outputs Output, Wrap pulse); the FSM drives Step and consumes Wrap for Overflow.

Verification
REQ-030 Reset, Start with Len=5 -> Busy high 5 cycles, Output 000,001,011,010,110,111, Done pulse 1 cycle, Overflow=0, Remaining 5..1 then 0.
REQ-031 From count=5, Start with Len=4 -> count 6,7,0,1 (Output 101,100,000,001), Overflow=1 from the 7->0 step; next Start clears it.
REQ-032 Start Len=6, Pause high for cycles 3-5 -> count frozen, Busy stays 1, state HOLD; resume adds 1 bubble cycle; total 6 steps, Done once.
REQ-033 Start Len=8, Abort at step 3 with Pause=1 -> IDLE next edge, count=3 (Output 010), Remaining=0, no Done; Start during run ignored.
REQ-034 Start Len=0 -> Done next cycle, count unchanged, Busy never high; Reset pulse mid-run between edges -> Output 000 immediately, no later Done.

Source files
------------

// File: rtl/gray_run_ctrl_pkg.sv
// Shared definitions for the Gray-code run controller: FSM encoding,
// counter width and the binary-to-Gray helper.
`default_nettype none

package gray_run_ctrl_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_run_ctrl_core.sv
// gray_core: 3-bit binary counter advanced by Step, presented as Gray code,
// with a Wrap pulse on the 7->0 step.
`default_nettype none

module gray_core
  import gray_run_ctrl_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Step,
  output logic [CNT_W-1:0] Output,
  output logic             Wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = Step ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output decodes the register alone so it only ever toggles one bit per step.
  assign Output = bin2gray(cnt_q);
  assign Wrap   = Step && (cnt_q == '1);

endmodule

`default_nettype wire

// File: rtl/gray_run_ctrl.sv
// gray_run_ctrl: runs a Gray counter for Len steps with pause/abort control,
// a one-cycle Done pulse and a sticky wrap flag.
`default_nettype none

module gray_run_ctrl
  import gray_run_ctrl_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Len,
  input  logic             Pause,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [LEN_W-1:0] Remaining,
  output logic [CNT_W-1:0] Output,
  output logic             Overflow
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             wrap;

  gray_core u_core (
    .Clk    (Clk),
    .Reset  (Reset),
    .Step   (step),
    .Output (Output),
    .Wrap   (wrap)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q | wrap;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          ovf_d = 1'b0;
          if (Len != '0) begin
            state_d = RUN;
            rem_d   = Len;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (Pause) begin
          state_d = HOLD;
        end else begin
          step  = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      HOLD: begin
        // Leaving HOLD costs one bubble edge; stepping resumes from RUN.
        if (Abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (!Pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy      = (state_q == RUN) || (state_q == HOLD);
  assign Done      = (state_q == DONE);
  assign Remaining = rem_q;
  assign Overflow  = ovf_q;

endmodule

`default_nettype wire
